// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam int unsigned DEF_STARVE_MAX = 4;
  localparam int unsigned DEF_TIMEOUT    = 15;
  localparam logic [3:0]  BE_FULL        = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive fetch denials; sat lets fetch override data priority.
module starve_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb sat = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between pipeline fetch (IF) and memory stage (DM):
// DM priority, IF anti-starvation, per-transaction timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [3:0]        cmd_be;
  logic              starve_sat;
  logic              busy;
  logic              expire;
  logic              done;

  starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (if_req && !if_gnt),
    .clr (!if_req || if_gnt),
    .sat (starve_sat)
  );

  always_comb begin
    busy      = (state != IDLE);
    dm_gnt    = (state == IDLE) && dm_req && !(if_req && starve_sat);
    if_gnt    = (state == IDLE) && if_req && !dm_gnt;
    expire    = busy && !mem_ready && (to_cnt == TO_W'(TIMEOUT));
    done      = busy && (mem_ready || expire);
    err       = expire;
    if_rvalid = done && (state == BUSY_IF);
    dm_rvalid = done && (state == BUSY_DM);
    // Timeout completions return zero data; only a real ready forwards memory data.
    if_rdata  = (state == BUSY_IF && mem_ready) ? mem_rdata : '0;
    dm_rdata  = (state == BUSY_DM && mem_ready) ? mem_rdata : '0;
    mem_en    = busy;
    mem_we    = busy && cmd_we;
    mem_addr  = busy ? cmd_addr  : '0;
    mem_wdata = busy ? cmd_wdata : '0;
    mem_be    = busy ? cmd_be    : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      to_cnt    <= '0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_gnt) begin
            cmd_we    <= dm_we;
            cmd_addr  <= dm_addr;
            cmd_wdata <= dm_wdata;
            cmd_be    <= dm_be;
            to_cnt    <= '0;
            state     <= BUSY_DM;
          end else if (if_gnt) begin
            cmd_we    <= 1'b0;
            cmd_addr  <= if_addr;
            cmd_wdata <= '0;
            cmd_be    <= BE_FULL;
            to_cnt    <= '0;
            state     <= BUSY_IF;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (mem_ready || expire) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter against a transaction-level reference.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;
  localparam int unsigned TMO  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic [3:0]    dm_be;
  logic          err, mem_en, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_be;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: who owns the memory (0 none, 1 fetch, 2 data), how many busy
  // cycles it has used, and how many consecutive cycles fetch has been refused.
  int            owner;
  int            used;
  int            refused;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [3:0]    c_be;
  logic          e_if_gnt, e_dm_gnt;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; used = 0; refused = 0;
    c_we = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
    e_if_gnt = 1'b0; e_dm_gnt = 1'b0;
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_rsp"}, {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, err}, '0);
    check({tag, "_mem"}, {mem_en, mem_we, mem_addr, mem_wdata, mem_be}, '0);
  endtask

  // Settle combinational outputs and compare everything against the reference.
  task automatic look();
    logic fin_ok, fin_to;
    #1;
    e_dm_gnt = (owner == 0) && dm_req && !(if_req && refused >= int'(SMAX));
    e_if_gnt = (owner == 0) && if_req && !e_dm_gnt;
    fin_ok   = (owner != 0) && mem_ready;
    fin_to   = (owner != 0) && !mem_ready && (used + 1 == int'(TMO) + 1);
    check("grant", {if_gnt, dm_gnt}, {e_if_gnt, e_dm_gnt});
    check("resp", {if_rvalid, if_rdata, dm_rvalid, dm_rdata, err},
          {(owner == 1) && (fin_ok || fin_to), (owner == 1 && fin_ok) ? mem_rdata : 32'h0,
           (owner == 2) && (fin_ok || fin_to), (owner == 2 && fin_ok) ? mem_rdata : 32'h0,
           fin_to});
    if (owner != 0)
      check("mem", {mem_en, mem_we, mem_addr, mem_wdata, mem_be}, {1'b1, c_we, c_addr, c_wdata, c_be});
    else
      check("mem", {mem_en, mem_we, mem_addr, mem_wdata, mem_be}, '0);
    if (if_req && !e_if_gnt) refused = (refused < int'(SMAX)) ? refused + 1 : int'(SMAX);
    else refused = 0;
    if (owner != 0) begin
      used++;
      if (fin_ok || fin_to) owner = 0;
    end else if (e_dm_gnt) begin
      owner = 2; used = 0;
      c_we = dm_we; c_addr = dm_addr; c_wdata = dm_wdata; c_be = dm_be;
    end else if (e_if_gnt) begin
      owner = 1; used = 0;
      c_we = 1'b0; c_addr = if_addr; c_wdata = '0; c_be = 4'hF;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int first_if, second_if, nbusy, err_at, rv_cnt;
  logic [DW-1:0] rd_at_err;
  logic          rv_at_err;

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    model_reset();
    #2;
    zero_check("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Lone fetch
    if_req = 1'b1; if_addr = 32'h40;
    look(); check("fetch_gnt", if_gnt, 1'b1); tick();
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    look();
    check("fetch_addr", {mem_en, mem_addr}, {1'b1, 32'h40});
    check("fetch_data", {if_rvalid, if_rdata}, {1'b1, 32'h0050_0093});
    tick();

    // Data write beats a simultaneous fetch
    mem_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
    look(); check("prio_gnt", {dm_gnt, if_gnt}, 2'b10); tick();
    dm_req = 1'b0; mem_ready = 1'b1;
    look();
    check("prio_mem", {mem_we, mem_be, mem_wdata}, {1'b1, 4'h3, 32'hDEAD_BEEF});
    check("prio_ack", dm_rvalid, 1'b1);
    tick();
    look(); tick();
    if_req = 1'b0;
    look(); tick();

    // Starvation: both requesters held, memory always ready
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; if_req = 1'b1; if_addr = 32'h44;
    mem_ready = 1'b1; first_if = -1; second_if = -1;
    for (int i = 0; i < 12; i++) begin
      mem_rdata = $urandom;
      look();
      if (if_gnt) begin
        if (first_if < 0) first_if = i;
        else if (second_if < 0) second_if = i;
      end
      tick();
    end
    check("starve_first", first_if, 4);
    check("starve_again", second_if, 10);
    dm_req = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
    look(); tick();
    look(); tick();

    // Timeout on a data read
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
    look(); tick();
    dm_req = 1'b0; nbusy = 0; err_at = -1; rv_at_err = 1'b0; rd_at_err = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      mem_rdata = $urandom;
      look();
      if (!mem_en) break;
      nbusy++;
      if (err) begin err_at = nbusy; rv_at_err = dm_rvalid; rd_at_err = dm_rdata; end
      tick();
    end
    check("to_len", nbusy, 16);
    check("to_err_at", err_at, 16);
    check("to_resp", {rv_at_err, rd_at_err}, {1'b1, 32'h0});
    tick();

    // Latency hold: ready after three wait cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h204; dm_wdata = 32'h1234_5678; dm_be = 4'hC;
    look(); tick();
    dm_req = 1'b0; rv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = (i == 3);
      look();
      if (i < 4) check("hold_cmd", {mem_en, mem_we, mem_addr, mem_be}, {1'b1, 1'b1, 32'h204, 4'hC});
      if (dm_rvalid) rv_cnt++;
      tick();
    end
    check("hold_rv_once", rv_cnt, 1);
    mem_ready = 1'b0;

    // Reset while a data access waits
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    look(); tick();
    dm_req = 1'b0;
    look(); tick();
    rst = 1'b0;
    #1;
    zero_check("rst_mid");
    model_reset();
    tick();
    rst = 1'b1; mem_ready = 1'b1;
    look(); check("rst_no_rv", dm_rvalid, 1'b0); tick();
    mem_ready = 1'b0;

    // Random traffic, with a long stall window to provoke timeouts
    e_if_gnt = 1'b0; e_dm_gnt = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (e_if_gnt || !if_req) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end
      if (e_dm_gnt || !dm_req) begin
        dm_req = ($urandom_range(0, 1) != 0);
        dm_we = $urandom_range(0, 1);
        dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom_range(0, 15));
      end
      mem_ready = (i >= 200 && i < 260) ? 1'b0 : ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      look();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-port unified instruction/data memory between two requesters: pipeline fetch (IF) and memory stage (DM).
- Sits between RISCV_pipeline and the memory block; the pipeline stalls IF while `if_req` is high and `if_gnt` is low.
- Request is sampled in IDLE, then held in a BUSY state until the memory returns `mem_ready`.
- Includes DM-priority arbitration with IF anti-starvation and a timeout per transaction.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive IF denials before IF is forced to win.
- TIMEOUT, 15, BUSY cycles without `mem_ready` before the transaction is aborted with error.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- if_req  in  1  fetch request, held until `if_gnt`.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- dm_req  in  1  data request, held until `dm_gnt`.
- dm_we  in  1  1 = write.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_be  in  4  byte enables.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  read data valid or write acknowledged.
- dm_rdata  out  DATA_W  read data.
- err  out  1  one-cycle pulse on timeout abort.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completes the current access this cycle.

Behaviour:
- States: IDLE, BUSY_IF, BUSY_DM.
- Reset (async, rst=0):
  - State goes to IDLE; `starve_cnt`, `to_cnt` and the latched command registers clear.
  - Every output is 0 (all outputs decode from IDLE or the cleared registers).
  - An in-flight transaction is dropped: no rvalid, no err.
- IDLE arbitration (combinational grant in the same cycle):
  - `dm_gnt` = dm_req && !(if_req && starve_cnt==STARVE_MAX).
  - `if_gnt` = if_req && !dm_gnt.
  - At most one gnt is high per cycle; gnt is never asserted outside IDLE.
- On the gnt edge:
  - Latch addr, we (IF: we=0), wdata, be (IF: be=4'hF) into the command register.
  - Move to BUSY_IF or BUSY_DM; `to_cnt` clears to 0.
- BUSY_x:
  - `mem_en`=1 and `mem_we`/`mem_addr`/`mem_wdata`/`mem_be` come from the command register, stable for the whole state.
  - If `mem_ready`=1: `x_rvalid`=1 combinationally the same cycle and `x_rdata`=mem_rdata, then go to IDLE.
  - Otherwise `to_cnt` increments.
  - If `to_cnt`==TIMEOUT and no ready: `err`=1 for that cycle, `x_rvalid`=1 with rdata=0, then go to IDLE.
- Outside a completing BUSY cycle, rdata outputs are 0.
- Throughput: minimum 2 cycles per transaction (IDLE grant + BUSY with ready); IDLE is always visited between transactions.
- `starve_cnt`:
  - Increments on each cycle with if_req=1 and if_gnt=0, in any state; saturates at STARVE_MAX.
  - Clears on if_gnt or if_req=0.
- Simultaneous requests in IDLE: DM wins unless `starve_cnt`==STARVE_MAX, in which case IF wins and `starve_cnt` clears.
- A `mem_ready` asserted in IDLE is ignored.
- Address arithmetic: pass-through, no alignment checking; `to_cnt` width is clog2(TIMEOUT+1).

Decomposition:
- Shared package `mem_arb_pkg`:
  - state encoding (IDLE=2'd0, BUSY_IF=2'd1, BUSY_DM=2'd2);
  - default STARVE_MAX and TIMEOUT;
  - the full-word byte-enable constant 4'hF.
- Sub-module `starve_counter`: saturating counter with inc/clr/sat outputs, parameterised by STARVE_MAX.

Test Plan:
- Reset mid-op: rst=0 while in BUSY_DM with mem_ready=0 -> state IDLE, all outputs 0, no dm_rvalid after rst=1.
- Lone fetch: if_req=1, if_addr=0x40, mem_ready=1 one cycle after grant, mem_rdata=0x00500093 -> if_gnt at cycle 0, mem_addr=0x40 with mem_en=1 at cycle 1, if_rvalid=1 and if_rdata=0x00500093 at cycle 1.
- DM write priority: if_req and dm_req both high, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_be=4'h3 -> dm_gnt=1 and if_gnt=0; next cycle mem_we=1, mem_be=4'h3, mem_wdata=0xDEADBEEF; dm_rvalid on ready.
- Starvation: dm_req held continuously, if_req held, mem_ready always 1 -> IF denied 4 times, then on the next IDLE if_gnt=1 and dm_gnt=0; starve_cnt returns to 0.
- Timeout: DM read granted, mem_ready held 0 -> exactly 16 BUSY cycles, err=1 and dm_rvalid=1 with dm_rdata=0 on the last one, then IDLE.
- Latency hold: mem_ready asserted after 3 wait cycles -> mem_addr/mem_we stable for all 4 BUSY cycles, single rvalid pulse.
